// File: rtl/audio_pkg.sv
// Shared audio types and I2S constants for the effects-chain output path.
//   sample_t         : one signed channel sample at the effects-chain width
//   stereo_sample_t  : left/right pair as produced by the distortion stage
//   I2S_SLOT_BITS    : default BCLK periods per channel slot
//   I2S_LR_LEFT      : word-select level that marks the left channel
package audio_pkg;

  localparam int   AUDIO_SAMPLE_WIDTH = 16;
  localparam int   I2S_SLOT_BITS      = 32;
  localparam logic I2S_LR_LEFT        = 1'b0;

  typedef logic signed [AUDIO_SAMPLE_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock generator. Divides clk down to BCLK and flags the clk cycle
// on which BCLK is about to change, so the parent can update its own
// registers on exactly the same edge as BCLK.
//   clk, reset : system clock, synchronous active-high reset
//   bclk       : registered bit clock (reset low)
//   rise_stb   : high in the cycle whose edge takes bclk 0->1
//   fall_stb   : high in the cycle whose edge takes bclk 1->0
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             bclk_reg, bclk_next;
  logic             term_cnt;

  assign term_cnt = (div_cnt_reg == DIV_LAST);

  always_comb begin
    div_cnt_next = term_cnt ? '0 : div_cnt_reg + 1'b1;
    bclk_next    = term_cnt ? ~bclk_reg : bclk_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      bclk_reg    <= bclk_next;
    end
  end

  // Strobes are decoded from registers only, so they are clean in-fabric
  // enables that coincide with the edge that moves bclk.
  assign bclk     = bclk_reg;
  assign rise_stb = term_cnt & ~bclk_reg;
  assign fall_stb = term_cnt &  bclk_reg;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S master transmitter between the last effect stage and the codec DAC.
// Buffers one stereo pair behind the frame currently on the wire and
// shifts it out MSB first with the standard one-bit I2S delay.
//   clk, reset    : system clock, synchronous active-high reset
//   left_sample   : left channel sample (two's complement)
//   right_sample  : right channel sample (two's complement)
//   sample_valid  : pair on the inputs is valid
//   sample_ready  : holding register empty; pair taken on valid && ready
//   bclk          : I2S bit clock
//   lrclk         : I2S word select (0 = left, 1 = right)
//   sdata         : I2S serial data
//   frame_start   : one-cycle pulse when a frame is loaded into the shifter
//   underrun      : one-cycle pulse when that load found no pair waiting
module i2s_tx_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int SLOT_BITS    = I2S_SLOT_BITS,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] left_sample,
  input  logic [SAMPLE_WIDTH-1:0] right_sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_START = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] L_FIRST    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_LAST     = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] R_FIRST    = CNT_W'(SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] R_LAST     = CNT_W'(SLOT_BITS + SAMPLE_WIDTH);

  logic bclk_rise, bclk_fall;

  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic                    lrclk_reg, lrclk_next;
  logic                    sdata_reg, sdata_next;
  logic                    frame_start_reg, frame_start_next;
  logic                    underrun_reg, underrun_next;
  logic                    hold_empty_reg, hold_empty_next;
  logic [SAMPLE_WIDTH-1:0] hold_l_reg, hold_l_next;
  logic [SAMPLE_WIDTH-1:0] hold_r_reg, hold_r_next;
  logic [SAMPLE_WIDTH-1:0] shift_l_reg, shift_l_next;
  logic [SAMPLE_WIDTH-1:0] shift_r_reg, shift_r_next;
  logic                    accept;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .bclk     (bclk),
    .rise_stb (bclk_rise),
    .fall_stb (bclk_fall)
  );

  // A single divider edge can never be both a rise and a fall.
  assert property (@(posedge clk) !(bclk_rise && bclk_fall));

  assign accept = sample_valid && hold_empty_reg;

  always_comb begin
    bit_cnt_next     = bit_cnt_reg;
    lrclk_next       = lrclk_reg;
    sdata_next       = sdata_reg;
    frame_start_next = 1'b0;
    underrun_next    = 1'b0;
    hold_empty_next  = hold_empty_reg;
    hold_l_next      = hold_l_reg;
    hold_r_next      = hold_r_reg;
    shift_l_next     = shift_l_reg;
    shift_r_next     = shift_r_reg;

    if (bclk_fall) begin
      bit_cnt_next = (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + 1'b1;
      lrclk_next   = (bit_cnt_next >= SLOT_START) ? ~I2S_LR_LEFT : I2S_LR_LEFT;
      sdata_next   = 1'b0;

      if (bit_cnt_reg == LAST_BIT) begin
        // Frame boundary: bit 0 of the new frame is the delay bit, so the
        // shifter only needs loading here, nothing is driven from it yet.
        frame_start_next = 1'b1;
        hold_empty_next  = 1'b1;
        if (hold_empty_reg) begin
          underrun_next = 1'b1;
          shift_l_next  = '0;
          shift_r_next  = '0;
        end else begin
          shift_l_next  = hold_l_reg;
          shift_r_next  = hold_r_reg;
        end
      end else if (bit_cnt_next >= L_FIRST && bit_cnt_next <= L_LAST) begin
        sdata_next   = shift_l_reg[SAMPLE_WIDTH-1];
        shift_l_next = shift_l_reg << 1;
      end else if (bit_cnt_next >= R_FIRST && bit_cnt_next <= R_LAST) begin
        sdata_next   = shift_r_reg[SAMPLE_WIDTH-1];
        shift_r_next = shift_r_reg << 1;
      end
    end

    // An accept can only coincide with an underrun load (holding was empty),
    // so the fresh pair lands in holding for the following frame.
    if (accept) begin
      hold_empty_next = 1'b0;
      hold_l_next     = left_sample;
      hold_r_next     = right_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_reg     <= LAST_BIT;
      lrclk_reg       <= 1'b1;
      sdata_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
      hold_empty_reg  <= 1'b1;
      hold_l_reg      <= '0;
      hold_r_reg      <= '0;
      shift_l_reg     <= '0;
      shift_r_reg     <= '0;
    end else begin
      bit_cnt_reg     <= bit_cnt_next;
      lrclk_reg       <= lrclk_next;
      sdata_reg       <= sdata_next;
      frame_start_reg <= frame_start_next;
      underrun_reg    <= underrun_next;
      hold_empty_reg  <= hold_empty_next;
      hold_l_reg      <= hold_l_next;
      hold_r_reg      <= hold_r_next;
      shift_l_reg     <= shift_l_next;
      shift_r_reg     <= shift_r_next;
    end
  end

  assign sample_ready = hold_empty_reg;
  assign lrclk        = lrclk_reg;
  assign sdata        = sdata_reg;
  assign frame_start  = frame_start_reg;
  assign underrun     = underrun_reg;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer (SAMPLE_WIDTH=16, SLOT_BITS=32,
// BCLK_DIV=2). A negedge monitor rebuilds every complete frame from the
// BCLK-rise samples of sdata/lrclk; the main thread drives pairs and checks
// handshake/reset timing, then compares the captured frames.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] left_sample, right_sample;
  logic        sample_valid;
  logic        sample_ready, bclk, lrclk, sdata, frame_start, underrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2s_tx_serializer #(
    .SAMPLE_WIDTH (16),
    .SLOT_BITS    (32),
    .BCLK_DIV     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- frame monitor ----------------
  typedef struct packed {
    logic [63:0] sd;
    logic [63:0] lr;
    logic        ur;
  } frame_t;

  frame_t frames[$];
  frame_t cur_frame;
  int     bit_idx = -1;
  logic   bclk_q  = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      bit_idx = -1;
    end else if (frame_start) begin
      if (bit_idx == 64) frames.push_back(cur_frame);
      cur_frame    = '0;
      cur_frame.ur = underrun;
      bit_idx      = 0;
    end else if (bclk && !bclk_q && bit_idx >= 0 && bit_idx < 64) begin
      cur_frame.sd[bit_idx] = sdata;
      cur_frame.lr[bit_idx] = lrclk;
      bit_idx++;
    end
    bclk_q = bclk;
  end

  // Frame bit k is what the codec latches on the k-th BCLK rise after load.
  function automatic logic [63:0] expected_sd(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    v = '0;
    for (int k = 1; k <= 16; k++) v[k] = l[16-k];
    for (int k = 33; k <= 48; k++) v[k] = r[48-k];
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r, output logic fs_at_ready);
    int t;
    t = 0;
    @(negedge clk);
    left_sample  = l;
    right_sample = r;
    sample_valid = 1'b1;
    while (!sample_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check_value("send_timeout", 64'(t), 64'd0);
    fs_at_ready = frame_start;
    @(negedge clk);
    sample_valid = 1'b0;
    $display("sent pair left=%h right=%h after %0d wait cycles", l, r, t);
    check_value("ready_drop_after_accept", 64'(sample_ready), 64'd0);
  endtask

  task automatic wait_frame_start();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_start && t < 600);
    if (!frame_start) check_value("frame_start_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_bclk"},  64'(bclk),         64'd0);
    check_value({tag, "_lrclk"}, 64'(lrclk),        64'd1);
    check_value({tag, "_sdata"}, 64'(sdata),        64'd0);
    check_value({tag, "_ready"}, 64'(sample_ready), 64'd1);
    check_value({tag, "_fs"},    64'(frame_start),  64'd0);
    check_value({tag, "_ur"},    64'(underrun),     64'd0);
  endtask

  // Cycles 1..5 after reset release with no input: bclk rises at 2, falls
  // at 4; the first load (always an underrun here) pulses at 4.
  task automatic check_startup(input string tag);
    logic [4:0] e_bclk, e_fs, e_lr;
    e_bclk = 5'b00110;
    e_fs   = 5'b01000;
    e_lr   = 5'b00111;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_value($sformatf("%s_c%0d_bclk", tag, c + 1), 64'(bclk),     64'(e_bclk[c]));
      check_value($sformatf("%s_c%0d_fs", tag, c + 1),   64'(frame_start), 64'(e_fs[c]));
      check_value($sformatf("%s_c%0d_ur", tag, c + 1),   64'(underrun), 64'(e_fs[c]));
      check_value($sformatf("%s_c%0d_lr", tag, c + 1),   64'(lrclk),    64'(e_lr[c]));
      check_value($sformatf("%s_c%0d_sd", tag, c + 1),   64'(sdata),    64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] exp_l [10];
  logic [15:0] exp_r [10];
  logic        exp_ur[10];
  logic        fs;

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    left_sample  = '0;
    right_sample = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("t1_reset");
    reset = 1'b0;
    check_startup("t1_start");                       // frame 0: underrun

    send_pair(16'hA5C3, 16'h8001, fs);               // -> frame 1
    send_pair(16'h7FFF, 16'h8000, fs);               // waits for frame 1 load
    check_value("t3_wait_fs_a", 64'(fs), 64'd1);
    send_pair(16'h0001, 16'hFFFF, fs);               // waits for frame 2 load
    check_value("t3_wait_fs_b", 64'(fs), 64'd1);

    wait_frame_start();                              // frame 3
    check_value("t3_frame3_no_ur", 64'(underrun), 64'd0);
    wait_frame_start();                              // frame 4: nothing supplied
    check_value("t4_frame4_ur", 64'(underrun), 64'd1);
    send_pair(16'h1234, 16'h5678, fs);               // -> frame 5

    wait_frame_start();                              // frame 5
    check_value("t5_frame5_no_ur", 64'(underrun), 64'd0);
    repeat (255) @(negedge clk);                     // one cycle before frame 6 load
    check_value("t5_ready_before_load", 64'(sample_ready), 64'd1);
    check_value("t5_no_fs_before_load", 64'(frame_start), 64'd0);
    left_sample  = 16'hC001;
    right_sample = 16'h3FFE;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    $display("sent pair left=c001 right=3ffe in underrun load cycle");
    check_value("t5_load_fs", 64'(frame_start), 64'd1);
    check_value("t5_load_ur", 64'(underrun), 64'd1);
    check_value("t5_load_ready", 64'(sample_ready), 64'd0);
    wait_frame_start();                              // frame 7 carries C001/3FFE
    wait_frame_start();                              // frame 8: underrun

    send_pair(16'hDEAD, 16'hBEEF, fs);               // -> frame 9
    wait_frame_start();                              // frame 9 in flight
    send_pair(16'h5A5A, 16'hA5A5, fs);               // holding, never sent
    repeat (78) @(negedge clk);                      // bit_cnt = 20
    check_value("t6_mid_left_lrclk", 64'(lrclk), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("t6_reset");
    @(negedge clk);
    reset = 1'b0;
    check_startup("t6_start");                       // underrun proves holding cleared
    wait_frame_start();
    repeat (2) @(negedge clk);

    exp_l  = '{16'h0000, 16'hA5C3, 16'h7FFF, 16'h0001, 16'h0000,
               16'h1234, 16'h0000, 16'hC001, 16'h0000, 16'h0000};
    exp_r  = '{16'h0000, 16'h8001, 16'h8000, 16'hFFFF, 16'h0000,
               16'h5678, 16'h0000, 16'h3FFE, 16'h0000, 16'h0000};
    exp_ur = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    check_value("frame_count", 64'(frames.size()), 64'd10);
    for (int i = 0; i < 10 && i < frames.size(); i++) begin
      check_value($sformatf("frame%0d_sdata", i), frames[i].sd, expected_sd(exp_l[i], exp_r[i]));
      check_value($sformatf("frame%0d_lrclk", i), frames[i].lr, 64'hFFFF_FFFF_0000_0000);
      check_value($sformatf("frame%0d_underrun", i), 64'(frames[i].ur), 64'(exp_ur[i]));
      $display("frame %0d sdata=%h underrun=%0b", i, frames[i].sd, frames[i].ur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
